// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the requesting units and the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arb_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) ();
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_choice;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_c;
  logic                  rsp_cout;
  logic                  rsp_borrow;

  modport master (
    output req_valid, req_a, req_b, req_choice, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_cout, rsp_borrow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_choice, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_cout, rsp_borrow
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Sequence per operation: IDLE (grant) -> EXEC (ALU settles) -> RESP (tagged result).
module alu_share_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arb_if.slave     bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_choice,
  input  logic [WIDTH-1:0]   alu_c,
  input  logic               alu_cout,
  input  logic               alu_borrow,
  output logic [CNT_W-1:0]   ops_count
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [IDW-1:0]   last_q, id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       choice_q;
  logic             rsp_valid_q, rsp_cout_q, rsp_borrow_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_c_q;
  logic [CNT_W-1:0] cnt_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx, cand;
  logic [NREQ-1:0]  gnt_oh;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_oh = gnt_found ? (NREQ'(1) << gnt_idx) : '0;
  end

  assign bus.req_ready  = (state_q == StIdle && rst_n) ? gnt_oh : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.rsp_borrow = rsp_borrow_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_choice     = choice_q;
  assign ops_count      = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= IDW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      choice_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_c_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_borrow_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // Operands only load on a grant so the ALU inputs stay quiet when idle.
          if (gnt_found) begin
            a_q      <= bus.req_a[32'(gnt_idx) * WIDTH +: WIDTH];
            b_q      <= bus.req_b[32'(gnt_idx) * WIDTH +: WIDTH];
            choice_q <= bus.req_choice[32'(gnt_idx) * 2 +: 2];
            id_q     <= gnt_idx;
            last_q   <= gnt_idx;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_c_q      <= alu_c;
          rsp_cout_q   <= alu_cout;
          rsp_borrow_q <= alu_borrow;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: default build plus a CNT_W=4 build for counter wrap.
module tb_alu_share_arb;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb_if #(.WIDTH(W), .NREQ(N)) bus ();
  alu_share_arb_if #(.WIDTH(W), .NREQ(N)) bus2 ();

  logic [W-1:0]  alu_a, alu_b, alu_c, alu2_a, alu2_b, alu2_c;
  logic [1:0]    alu_choice, alu2_choice;
  logic          alu_cout, alu_borrow, alu2_cout, alu2_borrow;
  logic [15:0]   ops_count;
  logic [3:0]    ops2_count;

  // Reference ALU: 00 add, 01 sub, 10 and, 11 or; returns {borrow, cout, c}.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] ch);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (ch)
      2'b00:   return {1'b0, s};
      2'b01:   return {(a < b), 1'b0, a - b};
      2'b10:   return {2'b00, a & b};
      default: return {2'b00, a | b};
    endcase
  endfunction

  assign {alu_borrow, alu_cout, alu_c}    = alu_f(alu_a, alu_b, alu_choice);
  assign {alu2_borrow, alu2_cout, alu2_c} = alu_f(alu2_a, alu2_b, alu2_choice);

  alu_share_arb #(.WIDTH(W), .NREQ(N), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_choice (alu_choice),
    .alu_c      (alu_c),
    .alu_cout   (alu_cout),
    .alu_borrow (alu_borrow),
    .ops_count  (ops_count)
  );

  alu_share_arb #(.WIDTH(W), .NREQ(N), .CNT_W(4)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus2.slave),
    .alu_a      (alu2_a),
    .alu_b      (alu2_b),
    .alu_choice (alu2_choice),
    .alu_c      (alu2_c),
    .alu_cout   (alu2_cout),
    .alu_borrow (alu2_borrow),
    .ops_count  (ops2_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] ch);
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
    bus.req_choice[i*2 +: 2] = ch;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a = '0; bus.req_b = '0; bus.req_choice = '0; bus.rsp_ready = 1'b0;
    bus2.req_valid = '0;
    bus2.req_a = '0; bus2.req_b = '0; bus2.req_choice = '0; bus2.rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (bus.req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
      end
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid);
      end
      n_checks++;
      if (ops_count !== 16'd0) begin
        n_fail++; $display("FAIL reset_ops: got %0d want 0", ops_count);
      end
      n_checks++;
      if (alu_a !== 8'h00) begin
        n_fail++; $display("FAIL reset_alu_a: got %h want 00", alu_a);
      end
    end
    n_checks++;
    if (ops2_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_ops2: got %0d want 0", ops2_count);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL release_ready: got %b want 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_single();
    set_req(2, 8'hF0, 8'h20, 2'b00);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    n_checks++;
    if (alu_a !== 8'hF0) begin
      n_fail++; $display("FAIL single_alu_a: got %h want f0", alu_a);
    end
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_cout} !== {1'b1, 2'd2, 8'h10, 1'b1}) begin
      n_fail++; $display("FAIL single_rsp: got v=%b id=%0d c=%h co=%b want v=1 id=2 c=10 co=1",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_cout);
    end
    step();
    n_checks++;
    if (ops_count !== 16'd1) begin
      n_fail++; $display("FAIL single_ops: got %0d want 1", ops_count);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_c [4];
    int unsigned prev, w;
    logic [3:0] exp_oh;
    exp_c[0] = 8'h11; exp_c[1] = 8'h1E; exp_c[2] = 8'h00; exp_c[3] = 8'h44;
    prev = 0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 8'h10, 8'h01, 2'b00);
    set_req(1, 8'h20, 8'h02, 2'b01);
    set_req(2, 8'h30, 8'h03, 2'b10);
    set_req(3, 8'h40, 8'h04, 2'b11);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) begin
      w = 0;
      while (bus.req_ready === 4'b0000 && w < 10) begin
        step();
        w++;
      end
      exp_oh = 4'b0001 << (n % 4);
      n_checks++;
      if (bus.req_ready !== exp_oh) begin
        n_fail++; $display("FAIL fair_grant%0d: got %b want %b", n, bus.req_ready, exp_oh);
      end
      if (n > 0) begin
        n_checks++;
        if (cyc - prev !== 3) begin
          n_fail++; $display("FAIL fair_gap%0d: got %0d want 3", n, cyc - prev);
        end
      end
      prev = cyc;
      step();
      step();
      if (n == 5) bus.req_valid = '0;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(n % 4) || bus.rsp_c !== exp_c[n % 4]) begin
        n_fail++; $display("FAIL fair_rsp%0d: got v=%b id=%0d c=%h want v=1 id=%0d c=%h",
                           n, bus.rsp_valid, bus.rsp_id, bus.rsp_c, n % 4, exp_c[n % 4]);
      end
      step();
    end
    n_checks++;
    if (ops_count !== 16'd6) begin
      n_fail++; $display("FAIL fair_ops: got %0d want 6", ops_count);
    end
  endtask

  task automatic test_backpressure();
    set_req(3, 8'h05, 8'h07, 2'b01);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_grant: got %b want 1000", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_cout, bus.rsp_borrow, bus.req_ready}
          !== {1'b1, 2'd3, 8'hFE, 1'b0, 1'b1, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold%0d: got v=%b id=%0d c=%h co=%b bo=%b rdy=%b want 1 3 fe 0 1 0000",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_cout,
                           bus.rsp_borrow, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    step();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0001 || ops_count !== 16'd7) begin
      n_fail++; $display("FAIL bp_release: got v=%b rdy=%b ops=%0d want 0 0001 7",
                         bus.rsp_valid, bus.req_ready, ops_count);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_reset_mid_exec();
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL mid_grant: got %b want 0010", bus.req_ready);
    end
    step();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_ready_in_reset: got %b want 0000", bus.req_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0 || ops_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_after: got rdy=%b v=%b ops=%0d want 0001 0 0",
                         bus.req_ready, bus.rsp_valid, ops_count);
    end
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_rsp%0d: got %b want 0", c, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_counter_wrap();
    int unsigned w;
    logic [3:0] exp;
    bus2.req_a[7:0] = 8'h01;
    bus2.req_b[7:0] = 8'h01;
    bus2.req_choice[1:0] = 2'b00;
    bus2.req_valid = 4'b0001;
    bus2.rsp_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      w = 0;
      while (bus2.rsp_valid !== 1'b1 && w < 10) begin
        step();
        w++;
      end
      step();
      if (k >= 15) begin
        exp = (k == 15) ? 4'd15 : (k == 16) ? 4'd0 : 4'd1;
        n_checks++;
        if (ops2_count !== exp) begin
          n_fail++; $display("FAIL wrap_op%0d: got %0d want %0d", k, ops2_count, exp);
        end
      end
    end
    bus2.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid_exec();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
